keccak_rhopi_inv_serial: RTL and testbench
==========================================

Name: keccak_rhopi_inv_serial

Overview:
Lane-serial inverse of the Keccak rho+pi step, used on the verify/unwind path of the SHA3 core. It accepts a 25-lane permuted state one 64-bit lane per cycle over a valid/ready handshake and buffers the whole state. It then emits the pre-rho/pi state lane by lane in natural order (lane 0..24), each lane reconstructed as orig[i] = rotr(perm[src(i)], r(i)).

Parameters:
LANE_W, 64, lane width; fixed at 64, any other value is unsupported.
NUM_LANES, 25, lanes per state; fixed at 25.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data holds a permuted lane
in_ready  output  1  block can accept a lane
in_data  input  64  permuted lane; arrival order j = 0..24
in_last  input  1  marks lane 24; used only with RHOPI_INV_FRAME_CHECK_EN
out_valid  output  1  out_data holds a reconstructed lane
out_ready  input  1  downstream accepts the lane
out_data  output  64  reconstructed lane i
out_idx  output  5  index i of out_data
out_last  output  1  high with lane 24
frame_err  output  1  sticky framing error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = LOAD, in_cnt = 0, out_cnt = 0, all 25 buffer lanes = 0.
  - in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, frame_err = 0.
  - out_data = 0, because the buffer is 0.
- A reset asserted mid-LOAD or mid-DRAIN aborts the frame; no partial output follows.
- State LOAD:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: buf[in_cnt] <= in_data, then in_cnt++.
  - On the accept with in_cnt == 24: in_cnt <= 0 and state <= DRAIN.
- State DRAIN:
  - in_ready = 0, out_valid = 1.
  - out_idx = out_cnt; out_last = (out_cnt == 24).
  - On out_valid & out_ready: out_cnt++.
  - On the handshake with out_cnt == 24: out_cnt <= 0 and state <= LOAD. in_ready rises the next cycle; LOAD and DRAIN never overlap.
- Latency: out_valid rises the cycle after the 25th input handshake.
- Full frame throughput: 25 input cycles + 25 output cycles minimum.
- out_data is a combinational mux/rotate from the buffer registers only, with no input-to-output paths. It holds stable while out_valid & !out_ready.
- Inverse mapping, written i:src,rotr amount:
  - 0:0,0  1:10,1  2:20,62  3:5,28  4:15,27
  - 5:16,36  6:1,44  7:11,6  8:21,55  9:6,20
  - 10:7,3  11:17,10  12:2,43  13:12,25  14:22,39
  - 15:23,41  16:8,45  17:18,15  18:3,21  19:13,8
  - 20:14,18  21:24,2  22:9,61  23:19,56  24:4,14
- rotr(x,k) = {x[k-1:0], x[63:k]}; k = 0 is identity.
- in_valid is ignored while in DRAIN. out_ready is ignored while in LOAD.
- Handshake rules: the upstream must hold in_data stable while in_valid & !in_ready. The block never drops out_valid without a handshake.

Optional Feature:
RHOPI_INV_FRAME_CHECK_EN.
- Defined: on each accepted input, frame_err is set (sticky until rst) if in_last != (in_cnt == 24). Data flow and the lane counter are unaffected.
- Undefined: in_last is ignored and frame_err is tied 0.

Test Plan:
- Reset, then feed perm lane j = 64'(j) for j = 0..24 with out_ready = 1. Required outputs:
  - lane 0 = 0x0; lane 1 = rotr(10,1) = 0x5; lane 2 = rotr(20,62) = 0x50.
  - lane 3 = 0x0000_0050_0000_0000; lane 24 = rotr(4,14) = 0x0010_0000_0000_0000.
  - out_last only with out_idx = 24; out_valid rises 1 cycle after the 25th accept.
- Single-bit sweep: perm lane 10 = 0x1, all others 0.
  - Required: out lane 1 = 0x8000_0000_0000_0000, all other output lanes 0.
  - Repeat with perm lane 0 = 0x1: out lane 0 = 0x1.
- Round-trip: a random state passed through the forward rho/pi model, then this block, must reproduce the original 25 lanes, for 100 random states.
- Backpressure: randomise out_ready (50%) and in_valid gaps.
  - Required: out_data and out_idx stable while stalled; no lane lost or duplicated.
  - in_ready = 0 throughout DRAIN.
- Reset mid-frame: assert rst after 12 input lanes, then send a fresh full frame.
  - Required: out_valid = 0 immediately; the output equals only the second frame.
- With RHOPI_INV_FRAME_CHECK_EN defined:
  - in_last on lane 23 -> frame_err = 1 the next cycle, stays 1 until rst.
  - A correct frame leaves frame_err = 0.

Source files
------------

// File: rtl/keccak_rhopi_inv_serial_if.sv
// rtl/keccak_rhopi_inv_serial_if.sv - stream bundle for the lane-serial inverse rho/pi block
//
// Purpose : groups the input lane stream, the output lane stream and the
//           framing status of keccak_rhopi_inv_serial.
// Signals : in_valid/in_ready/in_data/in_last    permuted lanes in, order j = 0..24
//           out_valid/out_ready/out_data          reconstructed lanes out
//           out_idx/out_last                      lane index i and last-lane flag
//           frame_err                             sticky framing error
// Modports: slave  - the inverse rho/pi block
//           master - the environment driving it

interface keccak_rhopi_inv_serial_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_idx;
   logic        out_last;
   logic        frame_err;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last, frame_err
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last, frame_err
   );
endinterface

// File: rtl/keccak_rhopi_inv_serial.sv
// rtl/keccak_rhopi_inv_serial.sv - lane-serial inverse of the Keccak rho+pi step
//
// Purpose : buffers a 25-lane permuted state arriving one lane per handshake,
//           then emits the pre-rho/pi state in natural lane order, each lane
//           rebuilt as orig[i] = rotr(perm[src(i)], r(i)).
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - keccak_rhopi_inv_serial_if.slave (in/out lane streams,
//                  out_idx, out_last, frame_err)
// Options : RHOPI_INV_FRAME_CHECK_EN - when defined, frame_err flags any accepted
//           lane whose in_last disagrees with "this is lane 24"; when undefined,
//           in_last is ignored and frame_err stays 0.

module keccak_rhopi_inv_serial #(
   parameter int LANE_W    = 64,
   parameter int NUM_LANES = 25
) (
   input  logic                          clk,
   input  logic                          rst,
   keccak_rhopi_inv_serial_if.slave      bus
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_LANES - 1);

   typedef enum logic [0:0] {
      LOAD  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [4:0]         in_cnt_q, in_cnt_d;
   logic [4:0]         out_cnt_q, out_cnt_d;
   logic [LANE_W-1:0]  buf_q [NUM_LANES];
   logic [LANE_W-1:0]  buf_d [NUM_LANES];
   logic               frame_err_q, frame_err_d;

   logic               in_ready;
   logic               out_valid;
   logic [4:0]         src_sel;
   logic [5:0]         rot_amt;

   function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] x,
                                              input logic [5:0] k);
      logic [2*LANE_W-1:0] dbl;
      dbl = {x, x} >> k;
      return dbl[LANE_W-1:0];
   endfunction

   // Output lane i reads buffered (permuted) lane src and rotates it right
   // by the rho offset of lane i, undoing pi and rho in one step.
   always_comb begin
      src_sel = 5'd0;
      rot_amt = 6'd0;
      case (out_cnt_q)
         5'd0:    begin src_sel = 5'd0;  rot_amt = 6'd0;  end
         5'd1:    begin src_sel = 5'd10; rot_amt = 6'd1;  end
         5'd2:    begin src_sel = 5'd20; rot_amt = 6'd62; end
         5'd3:    begin src_sel = 5'd5;  rot_amt = 6'd28; end
         5'd4:    begin src_sel = 5'd15; rot_amt = 6'd27; end
         5'd5:    begin src_sel = 5'd16; rot_amt = 6'd36; end
         5'd6:    begin src_sel = 5'd1;  rot_amt = 6'd44; end
         5'd7:    begin src_sel = 5'd11; rot_amt = 6'd6;  end
         5'd8:    begin src_sel = 5'd21; rot_amt = 6'd55; end
         5'd9:    begin src_sel = 5'd6;  rot_amt = 6'd20; end
         5'd10:   begin src_sel = 5'd7;  rot_amt = 6'd3;  end
         5'd11:   begin src_sel = 5'd17; rot_amt = 6'd10; end
         5'd12:   begin src_sel = 5'd2;  rot_amt = 6'd43; end
         5'd13:   begin src_sel = 5'd12; rot_amt = 6'd25; end
         5'd14:   begin src_sel = 5'd22; rot_amt = 6'd39; end
         5'd15:   begin src_sel = 5'd23; rot_amt = 6'd41; end
         5'd16:   begin src_sel = 5'd8;  rot_amt = 6'd45; end
         5'd17:   begin src_sel = 5'd18; rot_amt = 6'd15; end
         5'd18:   begin src_sel = 5'd3;  rot_amt = 6'd21; end
         5'd19:   begin src_sel = 5'd13; rot_amt = 6'd8;  end
         5'd20:   begin src_sel = 5'd14; rot_amt = 6'd18; end
         5'd21:   begin src_sel = 5'd24; rot_amt = 6'd2;  end
         5'd22:   begin src_sel = 5'd9;  rot_amt = 6'd61; end
         5'd23:   begin src_sel = 5'd19; rot_amt = 6'd56; end
         5'd24:   begin src_sel = 5'd4;  rot_amt = 6'd14; end
         default: begin src_sel = 5'd0;  rot_amt = 6'd0;  end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      buf_d       = buf_q;
      frame_err_d = frame_err_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;

      case (state_q)
         LOAD: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               buf_d[in_cnt_q] = bus.in_data;
`ifdef RHOPI_INV_FRAME_CHECK_EN
               if (bus.in_last != (in_cnt_q == LAST_IDX)) begin
                  frame_err_d = 1'b1;
               end
`endif
               if (in_cnt_q == LAST_IDX) begin
                  in_cnt_d = 5'd0;
                  state_d  = DRAIN;
               end else begin
                  in_cnt_d = in_cnt_q + 5'd1;
               end
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               if (out_cnt_q == LAST_IDX) begin
                  out_cnt_d = 5'd0;
                  state_d   = LOAD;
               end else begin
                  out_cnt_d = out_cnt_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD;
         in_cnt_q    <= 5'd0;
         out_cnt_q   <= 5'd0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         frame_err_q <= frame_err_d;
         buf_q       <= buf_d;
      end
   end

`ifndef RHOPI_INV_FRAME_CHECK_EN
   logic unused_in_last;
   assign unused_in_last = bus.in_last;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_idx   = out_cnt_q;
   assign bus.out_last  = (out_cnt_q == LAST_IDX);
   assign bus.out_data  = rotr(buf_q[src_sel], rot_amt);
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_keccak_rhopi_inv_serial.sv
// tb/tb_keccak_rhopi_inv_serial.sv - self-checking bench for keccak_rhopi_inv_serial

module tb_keccak_rhopi_inv_serial;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   keccak_rhopi_inv_serial_if bus ();

   keccak_rhopi_inv_serial dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: Keccak rho offsets and pi destinations derived from
   // the algorithm definition, lane index = x + 5*y.
   int          rho  [25];
   int          dest [25];
   logic [63:0] orig_a [25];
   logic [63:0] perm_a [25];
   logic [63:0] exp_a  [25];
   logic [63:0] got_a  [25];

   function automatic logic [63:0] rotl64(input logic [63:0] v, input int k);
      if (k == 0) return v;
      return (v << k) | (v >> (64 - k));
   endfunction

   function automatic logic [63:0] rotr64(input logic [63:0] v, input int k);
      if (k == 0) return v;
      return (v >> k) | (v << (64 - k));
   endfunction

   function automatic void build_model();
      int x, y, nx;
      x = 1; y = 0;
      rho[0] = 0;
      for (int t = 0; t < 24; t++) begin
         rho[x + 5*y] = (((t + 1) * (t + 2)) / 2) % 64;
         nx = y;
         y  = (2*x + 3*y) % 5;
         x  = nx;
      end
      for (int xx = 0; xx < 5; xx++)
         for (int yy = 0; yy < 5; yy++)
            dest[xx + 5*yy] = yy + 5*((2*xx + 3*yy) % 5);
   endfunction

   function automatic void forward_rhopi();
      for (int i = 0; i < 25; i++) perm_a[dest[i]] = rotl64(orig_a[i], rho[i]);
   endfunction

   function automatic void expect_from_perm();
      for (int i = 0; i < 25; i++) exp_a[i] = rotr64(perm_a[dest[i]], rho[i]);
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Drives perm_a[first..last_excl-1]; in_last is raised on lane last_at.
   task automatic drive_lanes(input bit gaps, input int first, input int last_excl, input int last_at);
      int budget;
      for (int j = first; j < last_excl; j++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               bus.in_valid = 1'b0; bus.in_data = rand64();
               @(posedge clk); #1;
            end
         end
         bus.in_valid = 1'b1; bus.in_data = perm_a[j]; bus.in_last = (j == last_at);
         budget = 0;
         while (bus.in_ready !== 1'b1 && budget < 200) begin
            @(posedge clk); #1; budget++;
         end
         if (budget >= 200) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout lane %0d: in_ready=%b required 1", j, bus.in_ready);
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = rand64();
   endtask

   // Drains one frame into got_a, comparing each lane against exp_a.
   task automatic drain_frame(input bit bp);
      int          k, budget;
      logic [63:0] prev_data;
      logic [4:0]  prev_idx;
      bit          stalled;
      k = 0; budget = 0; stalled = 0; prev_data = '0; prev_idx = '0;
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL latency: out_valid=%b required 1 one cycle after last accept", bus.out_valid);
      end
      while (k < 25 && budget < 1000) begin
         bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_valid  = bp ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.in_data   = rand64();
         checks += 5;
         if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL out_valid k=%0d: got %b required 1", k, bus.out_valid); end
         if (bus.out_idx !== 5'(k)) begin errors++; $display("FAIL out_idx: got %0d required %0d", bus.out_idx, k); end
         if (bus.out_data !== exp_a[k]) begin errors++; $display("FAIL out_data lane %0d: got %h required %h", k, bus.out_data, exp_a[k]); end
         if (bus.out_last !== (k == 24)) begin errors++; $display("FAIL out_last lane %0d: got %b required %b", k, bus.out_last, (k == 24)); end
         if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_drain lane %0d: got %b required 0", k, bus.in_ready); end
         if (stalled) begin
            checks += 2;
            if (bus.out_data !== prev_data) begin errors++; $display("FAIL stall_data lane %0d: got %h required %h", k, bus.out_data, prev_data); end
            if (bus.out_idx !== prev_idx) begin errors++; $display("FAIL stall_idx: got %0d required %0d", bus.out_idx, prev_idx); end
         end
         got_a[k]  = bus.out_data;
         prev_data = bus.out_data;
         prev_idx  = bus.out_idx;
         stalled   = !bus.out_ready;
         @(posedge clk); #1;
         budget++;
         if (!stalled) k++;
      end
      bus.out_ready = 1'b0; bus.in_valid = 1'b0;
      if (k < 25) begin
         checks++; errors++;
         $display("FAIL drain_timeout: drained %0d lanes required 25", k);
      end
      checks += 2;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_drain_valid: got %b required 0", bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_drain_ready: got %b required 1", bus.in_ready); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0;
      @(posedge clk); #1;
      checks += 6;
      if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
      if (bus.out_idx !== 5'd0)   begin errors++; $display("FAIL reset_out_idx: got %0d required 0", bus.out_idx); end
      if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last: got %b required 0", bus.out_last); end
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", bus.frame_err); end
      if (bus.out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_counting();
      for (int j = 0; j < 25; j++) perm_a[j] = 64'(j);
      expect_from_perm();
      drive_lanes(1'b0, 0, 25, 24);
      drain_frame(1'b0);
      checks += 5;
      if (got_a[0] !== 64'h0) begin errors++; $display("FAIL count_lane0: got %h required 0", got_a[0]); end
      if (got_a[1] !== 64'h5) begin errors++; $display("FAIL count_lane1: got %h required 5", got_a[1]); end
      if (got_a[2] !== 64'h50) begin errors++; $display("FAIL count_lane2: got %h required 50", got_a[2]); end
      if (got_a[3] !== 64'h0000_0050_0000_0000) begin errors++; $display("FAIL count_lane3: got %h required 0000005000000000", got_a[3]); end
      if (got_a[24] !== 64'h0010_0000_0000_0000) begin errors++; $display("FAIL count_lane24: got %h required 0010000000000000", got_a[24]); end
   endtask

   task automatic test_single_bit();
      for (int j = 0; j < 25; j++) begin
         for (int m = 0; m < 25; m++) perm_a[m] = '0;
         perm_a[j] = (j == 10 || j == 0) ? 64'h1 : (64'h1 << $urandom_range(0, 63));
         expect_from_perm();
         drive_lanes(1'b0, 0, 25, 24);
         drain_frame(1'b0);
         if (j == 10) begin
            checks++;
            if (got_a[1] !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL bit_lane10: out lane1 %h required 8000000000000000", got_a[1]); end
         end
         if (j == 0) begin
            checks++;
            if (got_a[0] !== 64'h1) begin errors++; $display("FAIL bit_lane0: out lane0 %h required 1", got_a[0]); end
         end
      end
   endtask

   task automatic test_round_trip(input int n, input bit bp);
      for (int s = 0; s < n; s++) begin
         for (int i = 0; i < 25; i++) orig_a[i] = rand64();
         forward_rhopi();
         for (int i = 0; i < 25; i++) exp_a[i] = orig_a[i];
         drive_lanes(bp, 0, 25, 24);
         drain_frame(bp);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 25; i++) perm_a[i] = rand64();
      drive_lanes(1'b0, 0, 12, 24);
      rst = 1'b1;
      #1;
      checks += 3;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midload_valid: got %b required 0", bus.out_valid); end
      if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL midload_ready: got %b required 1", bus.in_ready); end
      if (bus.out_data !== 64'd0) begin errors++; $display("FAIL midload_data: got %h required 0", bus.out_data); end
      @(posedge clk); #1;
      rst = 1'b0;
      // Reset while draining must also kill the output immediately.
      drive_lanes(1'b0, 0, 25, 24);
      bus.out_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL middrain_valid: got %b required 0", bus.out_valid); end
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 25; i++) orig_a[i] = rand64();
      forward_rhopi();
      for (int i = 0; i < 25; i++) exp_a[i] = orig_a[i];
      drive_lanes(1'b1, 0, 25, 24);
      drain_frame(1'b0);
   endtask

   task automatic test_frame_check();
`ifdef RHOPI_INV_FRAME_CHECK_EN
      do_reset();
      for (int i = 0; i < 25; i++) perm_a[i] = rand64();
      expect_from_perm();
      drive_lanes(1'b0, 0, 23, 23);
      checks++;
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_before: got %b required 0", bus.frame_err); end
      drive_lanes(1'b0, 23, 24, 23);
      checks++;
      if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b required 1", bus.frame_err); end
      drive_lanes(1'b0, 24, 25, 23);
      drain_frame(1'b0);
      checks++;
      if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b required 1", bus.frame_err); end
      do_reset();
      checks++;
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_cleared: got %b required 0", bus.frame_err); end
      drive_lanes(1'b0, 0, 25, 24);
      drain_frame(1'b0);
      checks++;
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_good_frame: got %b required 0", bus.frame_err); end
`else
      for (int i = 0; i < 25; i++) perm_a[i] = rand64();
      expect_from_perm();
      drive_lanes(1'b0, 0, 25, 5);
      drain_frame(1'b0);
      checks++;
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_disabled: got %b required 0", bus.frame_err); end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      build_model();
      test_reset();
      test_counting();
      test_single_bit();
      test_round_trip(100, 1'b0);
      test_round_trip(20, 1'b1);
      test_reset_mid_frame();
      test_frame_check();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
